// File: rtl/teclado_pkg.sv
// -----------------------------------------------------------------------------
// teclado_pkg
//   Shared definitions for the keypad PIN path: special key codes, the digit
//   classifier and the PIN-entry state type.
// -----------------------------------------------------------------------------
package teclado_pkg;

    // '#' confirms the entry, '*' clears it.
    localparam logic [3:0] KEY_CONFIRMA = 4'hE;
    localparam logic [3:0] KEY_LIMPA    = 4'hF;

    // IDLE: buffer empty. ENTRY: at least one digit collected.
    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } estado_senha_t;

    // Key codes 0x0-0x9 are numeric digits; 0xA-0xF are command/unused keys.
    function automatic logic is_digit(input logic [3:0] tecla);
        return (tecla <= 4'd9);
    endfunction

endpackage

// File: rtl/detector_de_borda.sv
// -----------------------------------------------------------------------------
// detector_de_borda
//   Rising-edge detector for a level signal. One flop holds the previous
//   level; the rise indication is the AND of the current level with the
//   inverted registered level, so it is high for exactly one cycle per
//   low-to-high transition, however long the input stays high.
// Ports
//   clk      in  1  system clock
//   rst      in  1  synchronous reset, active-high (clears the history flop)
//   i_sinal  in  1  level input
//   o_borda  out 1  high in the cycle where i_sinal is high and was low before
// -----------------------------------------------------------------------------
module detector_de_borda (
    input  logic clk,
    input  logic rst,
    input  logic i_sinal,
    output logic o_borda
);

    logic r_sinal_q;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sinal_q <= 1'b0;
        end else begin
            r_sinal_q <= i_sinal;
        end
    end

    assign o_borda = i_sinal & ~r_sinal_q;

endmodule

// File: rtl/acumulador_de_senha.sv
// -----------------------------------------------------------------------------
// acumulador_de_senha
//   Collects keypad digits into a PIN buffer. '*' clears the entry, '#'
//   delivers the collected digits as the confirmed code with a 1-cycle strobe,
//   and an entry left idle for TIMEOUT_CYC cycles is discarded with a 1-cycle
//   timeout strobe. Each key is taken once per rising edge of tecla_valid.
// Parameters
//   MAX_DIGITS   buffer capacity in digits (>=1)
//   TIMEOUT_CYC  idle cycles in ENTRY before the entry is discarded (>=2)
// Ports
//   clk           in  1            system clock
//   rst           in  1            synchronous reset, active-high
//   tecla_value   in  4            key code (0-9 digits, A-D unused, E '#', F '*')
//   tecla_valid   in  1            key valid level from the decoder
//   digitos       out 4*MAX_DIGITS live buffer, newest digit in [3:0]
//   num_digitos   out CW           live digit count
//   senha_out     out 4*MAX_DIGITS last confirmed code
//   senha_len     out CW           digit count of senha_out
//   senha_pronta  out 1            strobe: senha_out/senha_len updated
//   timeout       out 1            strobe: entry discarded by inactivity
// -----------------------------------------------------------------------------
module acumulador_de_senha
    import teclado_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    tecla_value,
    input  logic                          tecla_valid,
    output logic [4*MAX_DIGITS-1:0]       digitos,
    output logic [$clog2(MAX_DIGITS+1)-1:0] num_digitos,
    output logic [4*MAX_DIGITS-1:0]       senha_out,
    output logic [$clog2(MAX_DIGITS+1)-1:0] senha_len,
    output logic                          senha_pronta,
    output logic                          timeout
);

    localparam int DW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    localparam logic [CW-1:0] NUM_MAX  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] CNT_TERM = TW'(TIMEOUT_CYC - 1);

    estado_senha_t  r_estado;
    logic [DW-1:0]  r_digitos;
    logic [CW-1:0]  r_num;
    logic [TW-1:0]  r_cnt;
    logic [DW-1:0]  r_senha;
    logic [CW-1:0]  r_senha_len;
    logic           r_pronta;
    logic           r_timeout;

    logic           w_rise;
    logic [DW-1:0]  w_shifted;

    detector_de_borda u_borda (
        .clk     (clk),
        .rst     (rst),
        .i_sinal (tecla_valid),
        .o_borda (w_rise)
    );

    // Older digits move up one nibble, the new key enters at [3:0]. Nibbles
    // above the count stay zero because the buffer always starts from zero.
    assign w_shifted = (r_digitos << 4) | DW'(tecla_value);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado    <= IDLE;
            r_digitos   <= '0;
            r_num       <= '0;
            r_cnt       <= '0;
            r_senha     <= '0;
            r_senha_len <= '0;
            r_pronta    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_pronta  <= 1'b0;
            r_timeout <= 1'b0;

            if (w_rise) begin
                // Any accepted key edge restarts the inactivity window; a key
                // on the terminal-count cycle therefore wins over the timeout.
                r_cnt <= '0;
                if (is_digit(tecla_value)) begin
                    // A full buffer ignores further digits but still counts
                    // as activity.
                    if (r_num < NUM_MAX) begin
                        r_digitos <= w_shifted;
                        r_num     <= r_num + CW'(1);
                        r_estado  <= ENTRY;
                    end
                end else if (tecla_value == KEY_LIMPA) begin
                    r_digitos <= '0;
                    r_num     <= '0;
                    r_estado  <= IDLE;
                end else if (tecla_value == KEY_CONFIRMA) begin
                    if (r_num != '0) begin
                        r_senha     <= r_digitos;
                        r_senha_len <= r_num;
                        r_pronta    <= 1'b1;
                        r_digitos   <= '0;
                        r_num       <= '0;
                        r_estado    <= IDLE;
                    end
                end
            end else if (r_estado == ENTRY) begin
                if (r_cnt == CNT_TERM) begin
                    r_digitos <= '0;
                    r_num     <= '0;
                    r_cnt     <= '0;
                    r_timeout <= 1'b1;
                    r_estado  <= IDLE;
                end else begin
                    r_cnt <= r_cnt + TW'(1);
                end
            end
        end
    end

    assign digitos      = r_digitos;
    assign num_digitos  = r_num;
    assign senha_out    = r_senha;
    assign senha_len    = r_senha_len;
    assign senha_pronta = r_pronta;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_acumulador_de_senha.sv
// -----------------------------------------------------------------------------
// tb_acumulador_de_senha
//   Directed scenarios plus random key sequences. A PIN model (digit queue and
//   time of last activity) predicts each strobe and pushes it into a queue; an
//   independent monitor pops and compares whenever the DUT strobes.
// -----------------------------------------------------------------------------
module tb_acumulador_de_senha;

    localparam int MAX = 4;
    localparam int TO  = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  tecla_value = 4'h0;
    logic        tecla_valid = 1'b0;
    logic [15:0] digitos;
    logic [2:0]  num_digitos;
    logic [15:0] senha_out;
    logic [2:0]  senha_len;
    logic        senha_pronta;
    logic        timeout;

    acumulador_de_senha #(
        .MAX_DIGITS  (MAX),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_value  (tecla_value),
        .tecla_valid  (tecla_valid),
        .digitos      (digitos),
        .num_digitos  (num_digitos),
        .senha_out    (senha_out),
        .senha_len    (senha_len),
        .senha_pronta (senha_pronta),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_to;
        int          when;
        logic [15:0] senha;
        int          len;
    } ev_t;

    ev_t         exp_q[$];
    int          dq[$];        // collected digits, oldest first
    int          last_act;     // posedge number of last activity in ENTRY
    logic [15:0] exp_senha = '0;
    int          exp_len   = 0;

    function automatic logic [15:0] pack(input int d[$]);
        logic [15:0] s = '0;
        foreach (d[i]) s = (s << 4) | 16'(d[i]);
        return s;
    endfunction

    // Posedge q has no key edge: the entry dies if its window ends here.
    task automatic model_idle(input int q);
        ev_t e;
        if (dq.size() > 0 && q == last_act + TO) begin
            e.is_to = 1'b1; e.when = q; e.senha = exp_senha; e.len = exp_len;
            exp_q.push_back(e);
            dq.delete();
        end
    endtask

    // Posedge q carries a key edge with code k.
    task automatic model_key(input logic [3:0] k, input int q);
        ev_t e;
        if (k <= 4'd9) begin
            if (dq.size() < MAX) dq.push_back(int'(k));
            last_act = q;
        end else if (k == 4'hF) begin
            dq.delete();
        end else if (k == 4'hE) begin
            if (dq.size() > 0) begin
                exp_senha = pack(dq);
                exp_len   = dq.size();
                e.is_to = 1'b0; e.when = q; e.senha = exp_senha; e.len = exp_len;
                exp_q.push_back(e);
                dq.delete();
            end
        end else if (dq.size() > 0) begin
            last_act = q;
        end
    endtask

    // ---------------- driver helpers (called at a negedge) ----------------
    task automatic idle_cycles(input int n);
        repeat (n) begin
            model_idle(cyc + 1);
            @(negedge clk);
        end
    endtask

    // Key held for 'hold' cycles then released for 'gap' cycles (gap >= 1).
    task automatic press(input logic [3:0] k, input int hold, input int gap);
        model_key(k, cyc + 1);
        tecla_value = k;
        tecla_valid = 1'b1;
        @(negedge clk);
        check("live_digitos", 64'(digitos), 64'(pack(dq)));
        check("live_num", 64'(num_digitos), 64'(dq.size()));
        check("live_senha", 64'(senha_out), 64'(exp_senha));
        check("live_len", 64'(senha_len), 64'(exp_len));
        idle_cycles(hold - 1);
        tecla_valid = 1'b0;
        idle_cycles(gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digitos"}, 64'(digitos), 64'h0);
        check({tag, "_num"}, 64'(num_digitos), 64'h0);
        check({tag, "_senha"}, 64'(senha_out), 64'h0);
        check({tag, "_len"}, 64'(senha_len), 64'h0);
        check({tag, "_strobes"}, 64'({senha_pronta, timeout}), 64'h0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst && (senha_pronta || timeout)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 64'({senha_pronta, timeout}), 64'h0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("strobe_kind", 64'({senha_pronta, timeout}), e.is_to ? 64'h1 : 64'h2);
                check("strobe_cycle", 64'(cyc), 64'(e.when));
                check("strobe_senha", 64'(senha_out), 64'(e.senha));
                check("strobe_len", 64'(senha_len), 64'(e.len));
                check("strobe_buf_clear", 64'({num_digitos, digitos}), 64'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_cycles(2);

        // 1: full PIN then confirm
        press(4'h1, 3, 2); press(4'h2, 3, 2); press(4'h3, 3, 2); press(4'h4, 3, 2);
        press(4'hE, 3, 3);
        check("t1_senha", 64'(senha_out), 64'h1234);
        check("t1_len", 64'(senha_len), 64'h4);

        // 2: clear mid-entry, then one digit
        press(4'h7, 3, 2); press(4'h8, 3, 2); press(4'hF, 3, 2); press(4'h5, 3, 2);
        press(4'hE, 3, 3);
        check("t2_senha", 64'(senha_out), 64'h0005);

        // 3: overflow digits ignored; confirm from IDLE ignored
        for (int i = 1; i <= 6; i++) press(4'(i), 3, 2);
        press(4'hE, 3, 2);
        press(4'hE, 3, 3);
        check("t3_senha", 64'(senha_out), 64'h1234);

        // 4: long hold gives one digit, then timeout
        press(4'h9, 200, 60);
        check("t4_num", 64'(num_digitos), 64'h0);

        // 5: A restarts the window at cycle 48; key on the terminal cycle wins
        press(4'h3, 3, 45);
        press(4'hA, 3, 47);
        press(4'h7, 3, 60);

        // 6: reset mid-entry
        press(4'h6, 3, 2); press(4'h6, 3, 2);
        rst = 1'b1;
        dq.delete(); exp_senha = '0; exp_len = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("t6_rst");
        rst = 1'b0;
        idle_cycles(3);

        // random sequences
        for (int n = 0; n < 300; n++) begin
            logic [3:0] k;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6)       k = 4'($urandom_range(0, 9));
            else if (r == 6) k = 4'hE;
            else if (r == 7) k = 4'hF;
            else if (r == 8) k = 4'hE;
            else             k = 4'($urandom_range(10, 13));
            press(k, int'($urandom_range(1, 5)),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 60))
                                              : int'($urandom_range(1, 4)));
        end

        idle_cycles(70);
        check("pending_events", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
